fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of decode/execute in the core.
- Owns the program counter and issues word-address requests to the l1_cache instruction port.
- Buffers returned instructions, with their PCs, in a small prefetch FIFO and hands them to decode over a valid/ready handshake.
- Accepts redirects (branch/jump targets) from downstream: flushes buffered and in-flight fetches, then restarts at the new PC.

Parameters:
- PC_W, 16, program counter width (word addressed).
- RESET_PC, 16'd0, PC fetched first after reset.
- DEPTH, 4, prefetch FIFO entries (power of two, >=2).
- MAX_INFLIGHT, 2, max outstanding icache requests (1..DEPTH).

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-low reset.
- clk_en  in  1  global advance enable; when 0, all state holds and no request issues.
- icache_req  out  1  request strobe, one per accepted fetch.
- icache_addr  out  6  word address, equals pc[5:0].
- icache_data  in  32  returned instruction word.
- icache_ready  in  1  one in-order response per cycle it is high.
- redirect  in  1  flush and restart strobe.
- redirect_pc  in  PC_W  restart target.
- dec_valid  out  1  FIFO head valid.
- dec_instr  out  32  head instruction.
- dec_pc  out  PC_W  head instruction's PC.
- dec_ready  in  1  decode consumes the head this cycle.

Behaviour:
- Reset (rst=0, asynchronous): pc=RESET_PC, FIFO empty, inflight=0, discard=0, icache_req=0, dec_valid=0, dec_instr=0, dec_pc=0.
- All updates occur on posedge clk and only when clk_en=1.
- Issue rule: icache_req=1 when count+inflight<DEPTH and inflight<MAX_INFLIGHT and redirect=0.
  - icache_req is combinational from registered state.
  - On issue, pc<=pc+1 (wraps modulo 2^PC_W); the issued PC is pushed into a PC-tag queue of MAX_INFLIGHT entries.
- Response rule, icache_ready=1:
  - If discard>0: decrement discard, drop the data, pop the tag.
  - Else: push {icache_data, tag} into the FIFO and pop the tag.
  - icache_ready with inflight=0 is a protocol error: assertion fires, response ignored.
- inflight update: +1 on issue, -1 on response, unchanged when both happen in the same cycle.
- Decode handshake:
  - Pop occurs when dec_valid and dec_ready are both 1.
  - dec_instr/dec_pc come straight from the FIFO head (show-ahead, zero latency).
  - Push and pop in the same cycle leave count unchanged.
  - The space check counts inflight, so the FIFO never overflows and a full FIFO needs no push-side stall.
- Latency: redirect or reset in cycle N -> request issued in N+1 -> earliest dec_valid in N+2 with 1-cycle icache.
- Redirect (highest priority):
  - pc<=redirect_pc; FIFO cleared; discard<=inflight minus any response accepted this cycle; tag queue marked to discard.
  - No issue in the redirect cycle.
  - A same-cycle dec_ready pop is permitted but irrelevant, since the FIFO is cleared.
  - Back-to-back redirects: the last one wins; discard accumulates correctly.
- Reset mid-operation drops everything. The icache must also be reset, so no stale responses arrive.

Optional Feature:
- Macro FETCH_JUMP_PREDECODE_EN.
- Defined:
  - A non-discarded response with opcode icache_data[31:26]==2 is still pushed to the FIFO.
  - The fetch unit then self-redirects in the next cycle: target = tag+1+sext(icache_data[25:0]), truncated to PC_W.
  - Effect as an internal redirect: in-flight younger fetches discarded; FIFO entries older than the jump kept, younger ones flushed.
  - External redirect in that same cycle takes precedence.
- Undefined: opcode 2 treated as ordinary data; jumps resolve only via the redirect port.

Decomposition:
- Package core_pkg: PC_W, OPC_J=6'd2, opcode field slice constants, instr_t (32-bit) and fetch_entry_t {instr, pc} typedefs.
- One sub-module: fetch_fifo, a show-ahead FIFO with synchronous clear, parameterized on DEPTH and entry type.
- Tag queue may reuse fetch_fifo with depth MAX_INFLIGHT.

Test Plan:
- Reset release, dec_ready=1, 1-cycle icache returning word=addr -> dec_pc 0,1,2,... one per cycle from cycle 2; icache_addr wraps 63->0 at pc=64.
- dec_ready=0 held -> exactly DEPTH entries buffered, icache_req low; dec_ready=1 -> 4 entries drain in order, issue resumes.
- Redirect to 0x20 with inflight=2 -> next two icache_ready responses dropped; first dec_pc after redirect = 0x20.
- icache_ready stalled 5 cycles then burst -> inflight never exceeds MAX_INFLIGHT, order preserved, no loss or duplication.
- clk_en=0 for 3 cycles mid-stream -> all outputs and state frozen, stream resumes unchanged.
- FETCH_JUMP_PREDECODE_EN: word at pc 5 = {6'd2, 26'd10} -> jump delivered, next dec_pc=16, pcs 6/7 never delivered.

Source files
------------

// File: rtl/core_pkg.sv
// Shared fetch types and instruction-field constants.
package core_pkg;

  localparam int unsigned PC_W    = 16;
  localparam int unsigned INSTR_W = 32;
  localparam int unsigned ADDR_W  = 6;
  localparam int unsigned OPC_MSB = 31;
  localparam int unsigned OPC_LSB = 26;
  localparam int unsigned IMM_W   = 26;
  localparam logic [OPC_MSB-OPC_LSB:0] OPC_J = 6'd2;

  typedef logic [INSTR_W-1:0] instr_t;
  typedef logic [PC_W-1:0]    pc_t;

  typedef struct packed {
    instr_t instr;
    pc_t    pc;
  } fetch_entry_t;

  // True when the word carries the direct-jump opcode
  function automatic logic is_jump(input instr_t ins);
    return ins[OPC_MSB:OPC_LSB] == OPC_J;
  endfunction

  // Jump target relative to the following word, truncated to the PC width
  function automatic pc_t jump_target(input pc_t tag, input instr_t ins);
    logic [31:0] off;
    off = {{(32-IMM_W){ins[IMM_W-1]}}, ins[IMM_W-1:0]};
    return pc_t'(32'(tag) + 32'd1 + off);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Show-ahead FIFO with synchronous clear; head is visible combinationally.
module fetch_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter type         T     = logic [31:0]
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       push,
  input  T                           din,
  input  logic                       pop,
  output T                           dout,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  T                r_mem [DEPTH];
  logic [AW-1:0]   r_wr;
  logic [AW-1:0]   r_rd;
  logic [CW-1:0]   r_cnt;

  // Pointer advance that wraps at DEPTH, so non power-of-two depths work
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (32'(p) == DEPTH - 1) ? '0 : p + 1'b1;
  endfunction

  // Storage write; a clear discards the same-cycle push
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
    end else if (push && !clr) begin
      r_mem[r_wr] <= din;
    end
  end

  // Pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else if (clr) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (push) r_wr <= ptr_inc(r_wr);
      if (pop)  r_rd <= ptr_inc(r_rd);
      if (push != pop) r_cnt <= push ? r_cnt + 1'b1 : r_cnt - 1'b1;
    end
  end

  assign dout  = r_mem[r_rd];
  assign empty = (r_cnt == '0);
  assign count = r_cnt;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues icache requests, buffers
// returned words with their PCs and hands them to decode.
// Optional FETCH_JUMP_PREDECODE_EN: self-redirect on buffered direct jumps.
module fetch_unit
  import core_pkg::*;
#(
  parameter pc_t         RESET_PC     = '0,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned MAX_INFLIGHT = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clk_en,
  output logic               icache_req,
  output logic [ADDR_W-1:0]  icache_addr,
  input  logic [INSTR_W-1:0] icache_data,
  input  logic               icache_ready,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               dec_valid,
  output logic [INSTR_W-1:0] dec_instr,
  output logic [PC_W-1:0]    dec_pc,
  input  logic               dec_ready
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned INF_W = $clog2(MAX_INFLIGHT + 1);

  pc_t              r_pc;
  logic [INF_W-1:0] r_discard;

  logic [CNT_W-1:0] w_count;
  logic [INF_W-1:0] w_inflight;
  logic             w_fifo_empty;
  logic             w_tag_empty;
  pc_t              w_tag;
  fetch_entry_t     w_din;
  fetch_entry_t     w_head;
  logic             w_space;
  logic             w_issue;
  logic             w_resp;
  logic             w_drop;
  logic             w_push;
  logic             w_pop;
  logic             w_clr;
  logic             w_redir_int;
  pc_t              w_jump_tgt;

  // Issue, response and handshake qualifiers for this cycle
  always_comb begin
    w_space = ((32'(w_count) + 32'(w_inflight)) < DEPTH) &&
              (32'(w_inflight) < MAX_INFLIGHT);
    w_issue = rst & clk_en & ~redirect & ~w_redir_int & w_space;
    w_resp  = clk_en & icache_ready & ~w_tag_empty;
    w_drop  = (r_discard != '0) | redirect | w_redir_int;
    w_push  = w_resp & ~w_drop;
    w_pop   = clk_en & ~w_fifo_empty & dec_ready;
    w_clr   = clk_en & redirect;
    w_din   = '{instr: icache_data, pc: w_tag};
  end

  // PC advance/redirect and count of stale responses still to drop
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc      <= RESET_PC;
      r_discard <= '0;
    end else if (clk_en) begin
      if (redirect)         r_pc <= redirect_pc;
      else if (w_redir_int) r_pc <= w_jump_tgt;
      else if (w_issue)     r_pc <= r_pc + 1'b1;

      if (redirect | w_redir_int)
        r_discard <= w_inflight - INF_W'(w_resp);
      else if (w_resp && (r_discard != '0))
        r_discard <= r_discard - 1'b1;
    end
  end

`ifdef FETCH_JUMP_PREDECODE_EN
  logic r_jump_pend;
  pc_t  r_jump_tgt;

  // Arm a self-redirect for the cycle after a jump word is buffered
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_jump_pend <= 1'b0;
      r_jump_tgt  <= '0;
    end else if (clk_en) begin
      r_jump_pend <= w_push & is_jump(icache_data);
      if (w_push && is_jump(icache_data))
        r_jump_tgt <= jump_target(w_tag, icache_data);
    end
  end

  assign w_redir_int = r_jump_pend;
  assign w_jump_tgt  = r_jump_tgt;
`else
  assign w_redir_int = 1'b0;
  assign w_jump_tgt  = '0;
`endif

  // PCs of outstanding requests, in issue order; occupancy is the inflight count
  fetch_fifo #(
    .DEPTH (MAX_INFLIGHT),
    .T     (pc_t)
  ) u_tagq (
    .clk   (clk),
    .rst_n (rst),
    .clr   (1'b0),
    .push  (w_issue),
    .din   (r_pc),
    .pop   (w_resp),
    .dout  (w_tag),
    .empty (w_tag_empty),
    .count (w_inflight)
  );

  // Prefetch buffer feeding decode
  fetch_fifo #(
    .DEPTH (DEPTH),
    .T     (fetch_entry_t)
  ) u_pfq (
    .clk   (clk),
    .rst_n (rst),
    .clr   (w_clr),
    .push  (w_push),
    .din   (w_din),
    .pop   (w_pop),
    .dout  (w_head),
    .empty (w_fifo_empty),
    .count (w_count)
  );

  // A response with nothing outstanding means the icache lost sync
  a_no_orphan_resp: assert property (@(posedge clk) disable iff (!rst)
    !(clk_en && icache_ready && w_tag_empty));

  assign icache_req  = w_issue;
  assign icache_addr = r_pc[ADDR_W-1:0];
  assign dec_valid   = ~w_fifo_empty;
  assign dec_instr   = w_head.instr;
  assign dec_pc      = w_head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: bench-side icache with a random
// instruction image, and a stream model where, after reset or a redirect to X,
// fetch addresses and delivered PCs run X, X+1, ... in order.
module tb_fetch_unit;
  import core_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned MAXF  = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        clk_en;
  logic        icache_req;
  logic [5:0]  icache_addr;
  logic [31:0] icache_data;
  logic        icache_ready;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        dec_valid;
  logic [31:0] dec_instr;
  logic [15:0] dec_pc;
  logic        dec_ready;

  int unsigned n_vec;
  int unsigned n_err;
  logic [31:0] mem [64];
  logic [5:0]  q_addr [$];
  logic [15:0] exp_pc;
  logic [15:0] fetch_pc;

  fetch_unit #(
    .RESET_PC     (16'd0),
    .DEPTH        (DEPTH),
    .MAX_INFLIGHT (MAXF)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .clk_en       (clk_en),
    .icache_req   (icache_req),
    .icache_addr  (icache_addr),
    .icache_data  (icache_data),
    .icache_ready (icache_ready),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .dec_valid    (dec_valid),
    .dec_instr    (dec_instr),
    .dec_pc       (dec_pc),
    .dec_ready    (dec_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, sample, update the model, advance to next negedge
  task automatic cycle(input bit en, input bit rdy, input bit irdy, input bit redir,
                       input logic [15:0] tgt,
                       output logic o_v, output logic o_rq, output logic [31:0] o_pc,
                       output logic [31:0] o_ins, output logic [31:0] o_addr);
    clk_en       = en;
    dec_ready    = rdy;
    redirect     = redir;
    redirect_pc  = tgt;
    icache_ready = irdy && (q_addr.size() != 0);
    icache_data  = icache_ready ? mem[q_addr[0]] : 32'h0;
    #1;
    o_v    = dec_valid;
    o_rq   = icache_req;
    o_pc   = 32'(dec_pc);
    o_ins  = dec_instr;
    o_addr = 32'(icache_addr);
    if (!en) begin
      chk("req_when_frozen", 32'(icache_req), 32'd0);
    end else begin
      if (redir) chk("req_in_redirect", 32'(icache_req), 32'd0);
      if (!redir && dec_valid && rdy) begin
        chk("dec_pc", 32'(dec_pc), 32'(exp_pc));
        chk("dec_instr", dec_instr, mem[exp_pc[5:0]]);
        exp_pc = exp_pc + 16'd1;
      end
      if (icache_ready) void'(q_addr.pop_front());
      if (redir) begin
        exp_pc   = tgt;
        fetch_pc = tgt;
      end
      if (icache_req) begin
        chk("icache_addr", 32'(icache_addr), 32'(fetch_pc[5:0]));
        fetch_pc = fetch_pc + 16'd1;
        q_addr.push_back(icache_addr);
        chk("inflight_bound", 32'(q_addr.size() <= int'(MAXF)), 32'd1);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    logic        v, rq;
    logic [31:0] pc, ins, ad;
    logic        v0;
    logic [31:0] pc0, ins0, ad0;
    logic [31:0] w;
    int          n;
    bit          any, seen;

    n_vec = 0;
    n_err = 0;
    for (int i = 0; i < 64; i++) begin
      w = $urandom;
      if (w[31:26] == OPC_J) w[31:26] = 6'd3;
      mem[i] = w;
    end
    exp_pc       = 16'd0;
    fetch_pc     = 16'd0;
    rst          = 1'b0;
    clk_en       = 1'b1;
    dec_ready    = 1'b1;
    redirect     = 1'b0;
    redirect_pc  = 16'd0;
    icache_ready = 1'b0;
    icache_data  = 32'd0;

    // Reset values while held in reset with enable high
    repeat (2) @(negedge clk);
    chk("rst_icache_req", 32'(icache_req), 32'd0);
    chk("rst_dec_valid", 32'(dec_valid), 32'd0);
    chk("rst_dec_pc", 32'(dec_pc), 32'd0);
    chk("rst_dec_instr", dec_instr, 32'd0);
    chk("rst_icache_addr", 32'(icache_addr), 32'd0);
    rst = 1'b1;

    // Streaming from reset: first word at cycle 2, then one per cycle, addr wraps
    for (int i = 0; i < 72; i++) begin
      cycle(1, 1, 1, 0, 16'd0, v, rq, pc, ins, ad);
      if (i < 2) chk("startup_valid", 32'(v), 32'd0);
      else       chk("stream_valid", 32'(v), 32'd1);
    end

    // Backpressure: buffer fills, requests stop
    for (int i = 0; i < 12; i++) cycle(1, 0, 1, 0, 16'd0, v, rq, pc, ins, ad);
    chk("full_no_req", 32'(rq), 32'd0);
    chk("full_valid", 32'(v), 32'd1);
    chk("full_no_inflight", 32'(q_addr.size()), 32'd0);

    // Drain with icache stalled: exactly DEPTH entries, issue resumes
    n   = 0;
    any = 0;
    for (int i = 0; i < 6; i++) begin
      cycle(1, 1, 0, 0, 16'd0, v, rq, pc, ins, ad);
      if (v)  n++;
      if (rq) any = 1;
    end
    chk("drain_count", 32'(n), 32'(DEPTH));
    chk("issue_resumed", 32'(any), 32'd1);

    // Redirect with two requests outstanding
    chk("pre_redirect_inflight", 32'(q_addr.size()), 32'd2);
    cycle(1, 1, 0, 1, 16'h0020, v, rq, pc, ins, ad);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      cycle(1, 1, 1, 0, 16'd0, v, rq, pc, ins, ad);
      if (v && !seen) begin
        chk("first_after_redirect", pc, 32'h20);
        seen = 1;
      end
    end
    chk("redirect_delivered", 32'(seen), 32'd1);

    // Icache stall then burst
    for (int i = 0; i < 5; i++) cycle(1, 1, 0, 0, 16'd0, v, rq, pc, ins, ad);
    chk("stall_no_req", 32'(rq), 32'd0);
    chk("stall_inflight", 32'(q_addr.size()), 32'(MAXF));
    for (int i = 0; i < 12; i++) cycle(1, 1, 1, 0, 16'd0, v, rq, pc, ins, ad);

    // Enable low for three edges: everything holds
    cycle(0, 1, 1, 0, 16'd0, v0, rq, pc0, ins0, ad0);
    for (int k = 0; k < 3; k++) begin
      cycle(k == 2, 1, 1, 0, 16'd0, v, rq, pc, ins, ad);
      chk("frozen_valid", 32'(v), 32'(v0));
      chk("frozen_pc", pc, pc0);
      chk("frozen_instr", ins, ins0);
      chk("frozen_addr", ad, ad0);
    end
    for (int i = 0; i < 10; i++) cycle(1, 1, 1, 0, 16'd0, v, rq, pc, ins, ad);

    // Randomized mix of enable, backpressure, icache timing and redirects
    for (int i = 0; i < 500; i++) begin
      cycle($urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 2) != 0, $urandom_range(0, 24) == 0,
            16'($urandom), v, rq, pc, ins, ad);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
